// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller
//   Multi-cycle RV32 subset control FSM: fetch/decode/execute/mem/writeback.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_controller #(
  parameter int instr_width  = 32,
  parameter int alu_op_width = 4,
  parameter int cnt_width    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    imem_req,
  input  logic                    imem_ready,
  input  logic [instr_width-1:0]  imem_rdata,
  input  logic                    dmem_ready,
  output logic [instr_width-1:0]  instruction,
  output logic [alu_op_width-1:0] alu_op,
  output logic                    sel_bw_imm_rs2,
  output logic                    regfile_write_enable,
  output logic                    dmem_read_en,
  output logic                    dmem_write_en,
  output logic                    wr_back_sel,
  output logic                    pc_write_en,
  output logic                    illegal_instr,
  output logic [cnt_width-1:0]    retired_count,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    TRAP      = 3'd6
  } state_t;

  localparam logic [6:0] c_op_reg   = 7'b0110011;
  localparam logic [6:0] c_op_imm   = 7'b0010011;
  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;

  localparam logic [6:0] c_f7_zero = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;

  localparam logic [alu_op_width-1:0] c_alu_add  = alu_op_width'(0);
  localparam logic [alu_op_width-1:0] c_alu_sub  = alu_op_width'(1);
  localparam logic [alu_op_width-1:0] c_alu_sll  = alu_op_width'(2);
  localparam logic [alu_op_width-1:0] c_alu_slt  = alu_op_width'(3);
  localparam logic [alu_op_width-1:0] c_alu_sltu = alu_op_width'(4);
  localparam logic [alu_op_width-1:0] c_alu_xor  = alu_op_width'(5);
  localparam logic [alu_op_width-1:0] c_alu_srl  = alu_op_width'(6);
  localparam logic [alu_op_width-1:0] c_alu_sra  = alu_op_width'(7);
  localparam logic [alu_op_width-1:0] c_alu_or   = alu_op_width'(8);
  localparam logic [alu_op_width-1:0] c_alu_and  = alu_op_width'(9);

  localparam logic [cnt_width-1:0] c_cnt_one = {{(cnt_width-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [instr_width-1:0]   ir_q, ir_d;
  logic [cnt_width-1:0]     cnt_q, cnt_d;
  logic                     illegal_q, illegal_d;

  logic [6:0]               w_opcode;
  logic [2:0]               w_funct3;
  logic [6:0]               w_funct7;
  logic                     w_is_load;
  logic                     w_is_store;
  logic                     w_legal;
  logic [alu_op_width-1:0]  w_alu_op;
  logic                     w_imem_req;
  logic                     w_rf_we;
  logic                     w_rd_en;
  logic                     w_wr_en;
  logic                     w_pc_we;

  assign w_opcode   = ir_q[6:0];
  assign w_funct3   = ir_q[14:12];
  assign w_funct7   = ir_q[31:25];
  assign w_is_load  = (w_opcode == c_op_load);
  assign w_is_store = (w_opcode == c_op_store);

  always_comb begin
    w_legal = 1'b0;
    case (w_opcode)
      c_op_reg: begin
        w_legal = (w_funct7 == c_f7_zero) ||
                  ((w_funct7 == c_f7_alt) &&
                   ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
      end
      c_op_imm: begin
        case (w_funct3)
          3'b001:  w_legal = (w_funct7 == c_f7_zero);
          3'b101:  w_legal = (w_funct7 == c_f7_zero) || (w_funct7 == c_f7_alt);
          default: w_legal = 1'b1;
        endcase
      end
      c_op_load: begin
        w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) &&
                  (w_funct3 != 3'b111);
      end
      c_op_store: begin
        w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                  (w_funct3 == 3'b010);
      end
      default: w_legal = 1'b0;
    endcase
  end

  // funct7 only selects sub for register-register adds; addi's upper bits are immediate
  always_comb begin
    w_alu_op = c_alu_add;
    if (!(w_is_load || w_is_store)) begin
      case (w_funct3)
        3'b000:  w_alu_op = ((w_opcode == c_op_reg) && (w_funct7 == c_f7_alt)) ?
                            c_alu_sub : c_alu_add;
        3'b001:  w_alu_op = c_alu_sll;
        3'b010:  w_alu_op = c_alu_slt;
        3'b011:  w_alu_op = c_alu_sltu;
        3'b100:  w_alu_op = c_alu_xor;
        3'b101:  w_alu_op = (w_funct7 == c_f7_alt) ? c_alu_sra : c_alu_srl;
        3'b110:  w_alu_op = c_alu_or;
        default: w_alu_op = c_alu_and;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    illegal_d  = illegal_q;
    w_imem_req = 1'b0;
    w_rf_we    = 1'b0;
    w_rd_en    = 1'b0;
    w_wr_en    = 1'b0;
    w_pc_we    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!w_legal) begin
          illegal_d = 1'b1;
          state_d   = TRAP;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        state_d = (w_is_load || w_is_store) ? MEM : WRITEBACK;
      end
      MEM: begin
        // A store retires here; a load still needs its register write
        if (w_is_load) begin
          w_rd_en = 1'b1;
          if (dmem_ready) begin
            state_d = WRITEBACK;
          end
        end else begin
          w_wr_en = 1'b1;
          if (dmem_ready) begin
            w_pc_we = 1'b1;
            state_d = FETCH;
          end
        end
      end
      WRITEBACK: begin
        w_rf_we = 1'b1;
        w_pc_we = 1'b1;
        state_d = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cnt_d = w_pc_we ? (cnt_q + c_cnt_one) : cnt_q;

  assign imem_req             = w_imem_req;
  assign instruction          = ir_q;
  assign alu_op               = w_alu_op;
  assign sel_bw_imm_rs2       = !(w_is_load || w_is_store || (w_opcode == c_op_imm));
  assign regfile_write_enable = w_rf_we;
  assign dmem_read_en         = w_rd_en;
  assign dmem_write_en        = w_wr_en;
  assign wr_back_sel          = !w_is_load;
  assign pc_write_en          = w_pc_we;
  assign illegal_instr        = illegal_q;
  assign retired_count        = cnt_q;
  assign state                = state_q;

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter instr_width, default 32, meaning instruction and IR width.
REQ-002 SHALL have parameter alu_op_width, default 4, meaning ALU operation select width.
REQ-003 SHALL have parameter cnt_width, default 16, meaning retired-instruction counter width.
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port imem_req  output  1  instruction fetch request.
REQ-007 SHALL have port imem_ready  input  1  fetch data valid on imem_rdata this cycle.
REQ-008 SHALL have port imem_rdata  input  instr_width  fetched instruction.
REQ-009 SHALL have port dmem_ready  input  1  data-memory access completes this cycle.
REQ-010 SHALL have port instruction  output  instr_width  current IR contents.
REQ-011 SHALL have port alu_op  output  alu_op_width  ALU operation select.
REQ-012 SHALL have port sel_bw_imm_rs2  output  1  0 = immediate, 1 = rs2.
REQ-013 SHALL have ports regfile_write_enable, dmem_read_en, dmem_write_en, wr_back_sel (0 = memory, 1 = ALU), pc_write_en  output  1 each.
REQ-014 SHALL have port illegal_instr  output  1  sticky illegal-instruction flag.
REQ-015 SHALL have port retired_count  output  cnt_width  number of retired instructions.
REQ-016 SHALL have port state  output  3  current FSM state encoding.

Function
REQ-017 SHALL implement FSM states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, TRAP=6; IDLE -> FETCH unconditionally.
REQ-018 FETCH SHALL assert imem_req and hold it until imem_ready; on the imem_ready cycle, IR <= imem_rdata and the FSM moves to DECODE. No other enable is asserted in FETCH.
REQ-019 DECODE SHALL go to TRAP if the instruction is illegal, else to EXECUTE.
REQ-020 Legal instructions: opcode 0110011 with funct7 0000000 (any funct3) or funct7 0100000 (funct3 000/101 only); opcode 0010011 (funct3 001 needs funct7 0000000; funct3 101 needs funct7 0000000 or 0100000); opcode 0000011 with funct3 in {000,001,010,100,101}; opcode 0100011 with funct3 in {000,001,010}. Everything else is illegal.
REQ-021 alu_op encoding: add=0, sub=1, sll=2, slt=3, sltu=4, xor=5, srl=6, sra=7, or=8, and=9. It is decoded combinationally from IR in every state.
REQ-022 Decoding rules: loads and stores use add; funct3 101 with funct7 0100000 gives sra, otherwise srl; R-type funct3 000 with funct7 0100000 gives sub.
REQ-023 sel_bw_imm_rs2 SHALL be 0 for opcodes 0000011, 0010011 and 0100011, and 1 otherwise.
REQ-024 EXECUTE SHALL go to MEM for loads and stores, and to WRITEBACK for R-type and I-arith.
REQ-025 MEM SHALL hold dmem_read_en (load) or dmem_write_en (store) high until and including the dmem_ready cycle.
  - Load: then go to WRITEBACK.
  - Store: pc_write_en = 1 in the dmem_ready cycle, then go to FETCH.
REQ-026 WRITEBACK SHALL assert regfile_write_enable and pc_write_en for exactly one cycle, with wr_back_sel = 0 for loads and 1 otherwise, then go to FETCH.
REQ-027 Latency with zero wait states: R/I-arith 4 cycles, load 5, store 4; each wait cycle adds exactly one cycle.
REQ-028 retired_count SHALL increment by 1 in every pc_write_en cycle and wrap from all-ones to 0.
REQ-029 TRAP SHALL be absorbing: illegal_instr = 1, all enables and imem_req = 0, retired_count frozen; only reset exits.
REQ-030 imem_ready or dmem_ready outside FETCH or MEM respectively SHALL be ignored.

Reset
REQ-031 While rst_n = 0, state = IDLE, IR = 0, retired_count = 0, illegal_instr = 0, and all enables and imem_req = 0.
REQ-032 rst_n falling at any point (including mid-MEM or in TRAP) SHALL take effect immediately and abort the instruction with no write or pc update.

Verification
REQ-033 add x3,x1,x2 (0x002081B3), imem_ready high -> imem_req in cycle 1; DECODE, EXECUTE; WRITEBACK has regfile_write_enable = 1, alu_op = 0, sel = 1, wr_back_sel = 1; retired_count = 1.
REQ-034 lw x5,8(x1) (0x0080A283), dmem_ready delayed 2 cycles -> dmem_read_en high 3 cycles, alu_op = 0, sel = 0; WRITEBACK has wr_back_sel = 0; total 7 cycles.
REQ-035 sw x5,12(x1) (0x0050A623) -> dmem_write_en high until dmem_ready; pc_write_en in the same cycle; regfile_write_enable never 1.
REQ-036 srai x4,x1,3 (0x4030D213) -> alu_op = 7, sel = 0; then 0x4030D233 -> alu_op = 7, sel = 1.
REQ-037 0x0000007F -> TRAP after DECODE; illegal_instr stays 1 and imem_req 0 for 10 cycles; rst_n pulse -> IDLE with all outputs at reset values.
REQ-038 retired_count forced near wrap (cnt_width = 4, 16 retirements) -> value returns to 0; rst_n low during MEM -> no dmem_*_en or pc_write_en after the reset edge.
